// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - handshake and bus bundle for the writeback arbiter
//
// Purpose: groups every non-clock, non-reset signal of writeback_arbiter.
//   slave  : the arbiter side (consumes pipe/slow/lookup inputs, drives write port,
//            scoreboard, stall and forward outputs).
//   master : the surrounding pipeline / register file / decode side.
// Signals:
//   pipe_valid/pipe_rd/pipe_data           in-order pipeline result
//   slow_issue/slow_issue_rd               long-latency op issue (scoreboard set)
//   slow_valid/slow_ready/slow_rd/slow_data long-latency result handshake
//   wb_addr/wb_data                        register-file write port (addr 0 = no write)
//   busy                                   per-register scoreboard, bit 0 always 0
//   stall_req                              starvation stall request to decode
//   fwd_addr1/2, fwd_hit1/2, fwd_data1/2   decode source lookups against the write port
interface writeback_arbiter_if;
  typedef logic [31:0] Word;
  typedef logic [4:0]  RegAddress;

  logic        pipe_valid;
  RegAddress   pipe_rd;
  Word         pipe_data;
  logic        slow_issue;
  RegAddress   slow_issue_rd;
  logic        slow_valid;
  logic        slow_ready;
  RegAddress   slow_rd;
  Word         slow_data;
  RegAddress   wb_addr;
  Word         wb_data;
  logic [31:0] busy;
  logic        stall_req;
  RegAddress   fwd_addr1;
  RegAddress   fwd_addr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  Word         fwd_data1;
  Word         fwd_data2;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  slow_issue, slow_issue_rd,
    input  slow_valid, slow_rd, slow_data,
    output slow_ready,
    output wb_addr, wb_data, busy, stall_req,
    input  fwd_addr1, fwd_addr2,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output slow_issue, slow_issue_rd,
    output slow_valid, slow_rd, slow_data,
    input  slow_ready,
    input  wb_addr, wb_data, busy, stall_req,
    output fwd_addr1, fwd_addr2,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipeline and long-latency writes onto one register-file port
//
// Purpose: the pipeline result always wins the write port; long-latency results wait
//   in a one-entry hold buffer and drain whenever the pipeline is not writing a
//   non-zero register. A busy scoreboard tracks in-flight long-latency destinations,
//   a saturating starvation counter raises stall_req, and the registered write port
//   is forwarded to decode.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : writeback_arbiter_if.slave (see interface file for the signal list)
// Configuration macro: WRITEBACK_BYPASS_EN
//   defined   : forwarding active, busy clears at the drain edge
//   undefined : forwarding outputs tied to 0, busy clears one edge after the drain
module writeback_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  writeback_arbiter_if.slave   bus
);
  typedef logic [31:0] Word;
  typedef logic [4:0]  RegAddress;

  logic        hold_valid_q, hold_valid_d;
  RegAddress   hold_rd_q,    hold_rd_d;
  Word         hold_data_q,  hold_data_d;
  RegAddress   wb_addr_q,    wb_addr_d;
  Word         wb_data_q,    wb_data_d;
  logic [31:0] busy_q,       busy_d;
  logic [2:0]  cnt_q,        cnt_d;

  logic        pipe_wins;
  logic        drain;
  logic        accept;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

`ifndef WRITEBACK_BYPASS_EN
  // Delayed clear: remembers the register drained at the previous edge.
  logic        clr_pend_q, clr_pend_d;
  RegAddress   clr_rd_q,   clr_rd_d;
`endif

  always_comb begin
    pipe_wins = bus.pipe_valid && (bus.pipe_rd != '0);
    drain     = hold_valid_q && !pipe_wins;
    // Reset overrides every register below, so reset need not gate accept here.
    accept    = bus.slow_valid && !hold_valid_q;
    set_mask  = (bus.slow_issue && (bus.slow_issue_rd != '0)) ? (32'd1 << bus.slow_issue_rd) : 32'd0;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    if (drain) begin
      hold_valid_d = 1'b0;
    end
    // Results for x0 are accepted but never enter the buffer.
    if (accept && (bus.slow_rd != '0)) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = bus.slow_rd;
      hold_data_d  = bus.slow_data;
    end
  end

  always_comb begin
    wb_addr_d = '0;
    wb_data_d = wb_data_q;
    if (pipe_wins) begin
      wb_addr_d = bus.pipe_rd;
      wb_data_d = bus.pipe_data;
    end else if (drain) begin
      wb_addr_d = hold_rd_q;
      wb_data_d = hold_data_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!hold_valid_q || drain) begin
      cnt_d = '0;
    end else if (cnt_q != 3'd7) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

`ifdef WRITEBACK_BYPASS_EN
  always_comb begin
    clr_mask = drain ? (32'd1 << hold_rd_q) : 32'd0;
  end
`else
  always_comb begin
    clr_mask   = clr_pend_q ? (32'd1 << clr_rd_q) : 32'd0;
    // A newer issue to the same register at the drain edge owns the bit;
    // dropping the pending clear keeps it from being wiped one edge later.
    clr_pend_d = drain && !set_mask[hold_rd_q];
    clr_rd_d   = hold_rd_q;
  end
`endif

  always_comb begin
    // Set is applied after clear so the newer op wins.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      busy_q       <= '0;
      cnt_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

`ifndef WRITEBACK_BYPASS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_pend_q <= 1'b0;
      clr_rd_q   <= '0;
    end else begin
      clr_pend_q <= clr_pend_d;
      clr_rd_q   <= clr_rd_d;
    end
  end
`endif

  assign bus.slow_ready = !hold_valid_q && !reset;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.busy       = busy_q;
  assign bus.stall_req  = (cnt_q >= 3'd4);

`ifdef WRITEBACK_BYPASS_EN
  assign bus.fwd_hit1  = (wb_addr_q != '0) && (wb_addr_q == bus.fwd_addr1);
  assign bus.fwd_hit2  = (wb_addr_q != '0) && (wb_addr_q == bus.fwd_addr2);
  assign bus.fwd_data1 = bus.fwd_hit1 ? wb_data_q : '0;
  assign bus.fwd_data2 = bus.fwd_hit2 ? wb_data_q : '0;
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^{bus.fwd_addr1, bus.fwd_addr2};
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_hit2  = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed vector bench for writeback_arbiter
module tb_writeback_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  writeback_arbiter_if bus();

  writeback_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    bit          si;
    logic [4:0]  sird;
    bit          sv;
    logic [4:0]  srd;
    logic [31:0] sd;
    logic [4:0]  fa1;
    logic [4:0]  fa2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] busy_byp;
    logic [31:0] busy_nobyp;
    bit          stall;
    bit          rdy;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(bit chk, bit rst, bit pv, logic [4:0] prd, logic [31:0] pd,
                              bit si, logic [4:0] sird, bit sv, logic [4:0] srd, logic [31:0] sd,
                              logic [4:0] fa1, logic [4:0] fa2, logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] bb, logic [31:0] bn, bit st, bit rdy);
    vec_t v;
    v.chk = chk; v.rst = rst; v.pv = pv; v.prd = prd; v.pd = pd;
    v.si = si; v.sird = sird; v.sv = sv; v.srd = srd; v.sd = sd;
    v.fa1 = fa1; v.fa2 = fa2; v.wa = wa; v.wd = wd;
    v.busy_byp = bb; v.busy_nobyp = bn; v.stall = st; v.rdy = rdy;
    return v;
  endfunction

  task automatic check(string name, int row, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset = 1'b0;
    bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.slow_issue = 1'b0; bus.slow_issue_rd = '0;
    bus.slow_valid = 1'b0; bus.slow_rd = '0; bus.slow_data = '0;
    bus.fwd_addr1 = '0; bus.fwd_addr2 = '0;
  endtask

  task automatic check_fwd(int row, logic [4:0] wa, logic [31:0] wd);
    logic        h1, h2;
    logic [31:0] d1, d2;
`ifdef WRITEBACK_BYPASS_EN
    h1 = (wa != 0) && (wa == bus.fwd_addr1);
    h2 = (wa != 0) && (wa == bus.fwd_addr2);
    d1 = h1 ? wd : 32'd0;
    d2 = h2 ? wd : 32'd0;
`else
    h1 = 1'b0; h2 = 1'b0; d1 = 32'd0; d2 = 32'd0;
`endif
    check("fwd_hit1", row, 32'(bus.fwd_hit1), 32'(h1));
    check("fwd_hit2", row, 32'(bus.fwd_hit2), 32'(h2));
    check("fwd_data1", row, bus.fwd_data1, d1);
    check("fwd_data2", row, bus.fwd_data2, d2);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            chk rst pv prd pd           si sird sv srd sd            fa1 fa2  wa  wd            busy_b       busy_n       st rdy
    vecs[0]  = mk(0, 1, 0, 0,  0,            0, 0,   0, 0,  0,            0,  0,   0,  0,            0,           0,           0, 0);
    vecs[1]  = mk(1, 1, 0, 0,  0,            0, 0,   0, 0,  0,            0,  0,   0,  0,            0,           0,           0, 0);
    vecs[2]  = mk(1, 0, 1, 5,  123,          0, 0,   0, 0,  0,            0,  0,   0,  0,            0,           0,           0, 1);
    vecs[3]  = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            5,  6,   5,  123,          0,           0,           0, 1);
    vecs[4]  = mk(1, 0, 0, 0,  0,            1, 7,   0, 0,  0,            0,  0,   0,  123,          0,           0,           0, 1);
    vecs[5]  = mk(1, 0, 0, 0,  0,            0, 0,   1, 7,  32'hFFFFFFF7, 0,  0,   0,  123,          32'h80,      32'h80,      0, 1);
    vecs[6]  = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            7,  0,   0,  123,          32'h80,      32'h80,      0, 0);
    vecs[7]  = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            7,  7,   7,  32'hFFFFFFF7, 0,           32'h80,      0, 1);
    vecs[8]  = mk(1, 0, 0, 0,  0,            1, 3,   0, 0,  0,            0,  0,   0,  32'hFFFFFFF7, 0,           0,           0, 1);
    vecs[9]  = mk(1, 0, 1, 10, 32'h1009,     0, 0,   1, 3,  32'h33,       0,  0,   0,  32'hFFFFFFF7, 32'h8,       32'h8,       0, 1);
    vecs[10] = mk(1, 0, 1, 10, 32'h100A,     0, 0,   0, 0,  0,            0,  0,   10, 32'h1009,     32'h8,       32'h8,       0, 0);
    vecs[11] = mk(1, 0, 1, 10, 32'h100B,     0, 0,   0, 0,  0,            0,  0,   10, 32'h100A,     32'h8,       32'h8,       0, 0);
    vecs[12] = mk(1, 0, 1, 10, 32'h100C,     0, 0,   0, 0,  0,            0,  0,   10, 32'h100B,     32'h8,       32'h8,       0, 0);
    vecs[13] = mk(1, 0, 1, 10, 32'h100D,     0, 0,   0, 0,  0,            0,  0,   10, 32'h100C,     32'h8,       32'h8,       0, 0);
    vecs[14] = mk(1, 0, 1, 10, 32'h100E,     0, 0,   0, 0,  0,            0,  0,   10, 32'h100D,     32'h8,       32'h8,       1, 0);
    vecs[15] = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            0,  0,   10, 32'h100E,     32'h8,       32'h8,       1, 0);
    vecs[16] = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            3,  0,   3,  32'h33,       0,           32'h8,       0, 1);
    vecs[17] = mk(1, 0, 0, 0,  0,            1, 12,  1, 12, 32'hC0,       0,  0,   0,  32'h33,       0,           0,           0, 1);
    vecs[18] = mk(1, 0, 1, 0,  32'hDEAD,     0, 0,   0, 0,  0,            0,  0,   0,  32'h33,       32'h1000,    32'h1000,    0, 0);
    vecs[19] = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            0,  12,  12, 32'hC0,       0,           32'h1000,    0, 1);
    vecs[20] = mk(1, 0, 0, 0,  0,            1, 4,   1, 4,  32'h44,       0,  0,   0,  32'hC0,       0,           0,           0, 1);
    vecs[21] = mk(1, 0, 0, 0,  0,            1, 4,   0, 0,  0,            0,  0,   0,  32'hC0,       32'h10,      32'h10,      0, 0);
    vecs[22] = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            4,  0,   4,  32'h44,       32'h10,      32'h10,      0, 1);
    vecs[23] = mk(1, 0, 0, 0,  0,            0, 0,   1, 0,  32'h99,       0,  0,   0,  32'h44,       32'h10,      32'h10,      0, 1);
    vecs[24] = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            0,  0,   0,  32'h44,       32'h10,      32'h10,      0, 1);
    vecs[25] = mk(1, 0, 0, 0,  0,            1, 9,   0, 0,  0,            0,  0,   0,  32'h44,       32'h10,      32'h10,      0, 1);
    vecs[26] = mk(1, 0, 1, 11, 32'hBB,       0, 0,   1, 9,  32'h90,       0,  0,   0,  32'h44,       32'h210,     32'h210,     0, 1);
    vecs[27] = mk(1, 1, 1, 11, 32'hBB,       0, 0,   0, 0,  0,            0,  0,   11, 32'hBB,       32'h210,     32'h210,     0, 0);
    vecs[28] = mk(1, 0, 0, 0,  0,            0, 0,   0, 0,  0,            0,  0,   0,  0,            0,           0,           0, 1);

    for (int i = 0; i < 29; i++) begin
      reset             = vecs[i].rst;
      bus.pipe_valid    = vecs[i].pv;
      bus.pipe_rd       = vecs[i].prd;
      bus.pipe_data     = vecs[i].pd;
      bus.slow_issue    = vecs[i].si;
      bus.slow_issue_rd = vecs[i].sird;
      bus.slow_valid    = vecs[i].sv;
      bus.slow_rd       = vecs[i].srd;
      bus.slow_data     = vecs[i].sd;
      bus.fwd_addr1     = vecs[i].fa1;
      bus.fwd_addr2     = vecs[i].fa2;
      #1;
      if (vecs[i].chk) begin
        check("wb_addr", i, 32'(bus.wb_addr), 32'(vecs[i].wa));
        check("wb_data", i, bus.wb_data, vecs[i].wd);
`ifdef WRITEBACK_BYPASS_EN
        check("busy", i, bus.busy, vecs[i].busy_byp);
`else
        check("busy", i, bus.busy, vecs[i].busy_nobyp);
`endif
        check("stall_req", i, 32'(bus.stall_req), 32'(vecs[i].stall));
        check("slow_ready", i, 32'(bus.slow_ready), 32'(vecs[i].rdy));
        check_fwd(i, vecs[i].wa, vecs[i].wd);
      end
      step();
    end

    // Long blocking: the starvation counter must saturate at 7 rather than wrap.
    drive_idle();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd20; bus.pipe_data = 32'h55;
    bus.slow_valid = 1'b1; bus.slow_rd = 5'd21; bus.slow_data = 32'h77;
    #1;
    check("sat_accept_ready", 100, 32'(bus.slow_ready), 32'd1);
    step();
    bus.slow_valid = 1'b0; bus.slow_rd = '0; bus.slow_data = '0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      check("sat_stall", 100 + k, 32'(bus.stall_req), ((k - 1) >= 4) ? 32'd1 : 32'd0);
      check("sat_ready", 100 + k, 32'(bus.slow_ready), 32'd0);
      check("sat_wb_addr", 100 + k, 32'(bus.wb_addr), 32'd20);
      step();
    end
    bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    #1;
    check("sat_stall_at_drain", 111, 32'(bus.stall_req), 32'd1);
    step();

    // Bounded wait for the held value to reach the write port.
    begin
      int  budget;
      bit  seen;
      budget = 0;
      seen   = 1'b0;
      while (!seen && budget < 4) begin
        #1;
        if (bus.wb_addr == 5'd21) seen = 1'b1;
        else begin
          step();
          budget++;
        end
      end
      check("sat_drain_seen", 112, 32'(seen), 32'd1);
      check("sat_drain_latency", 112, budget, 0);
      check("sat_drain_data", 112, bus.wb_data, 32'h77);
      check("sat_stall_cleared", 112, 32'(bus.stall_req), 32'd0);
      check("sat_ready_back", 112, 32'(bus.slow_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
